// File: rtl/mux_tree_cfgchain_n_pkg.sv
// mux_tree_cfgchain_n_pkg: shared mode encodings and width helpers for the configurable mux cell
package mux_tree_cfgchain_n_pkg;

    localparam logic CFG_MODE_COMB = 1'b0;
    localparam logic CFG_MODE_REG  = 1'b1;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // the mode bit sits directly above the select field
    function automatic int mode_pos(input int n);
        return clog2(n);
    endfunction

endpackage

// File: rtl/mux_tree_comb_n.sv
// mux_tree_comb_n: N-input 2:1 basis mux tree, out-of-range selects read tied-off zero leaves
module mux_tree_comb_n
    import mux_tree_cfgchain_n_pkg::*;
#(
    parameter int NUM_INPUTS = 8,
    localparam int SEL_W = clog2(NUM_INPUTS)
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic [NUM_INPUTS-1:0] in,
    output logic                  out
);

    for (genvar l = 0; l <= SEL_W; l++) begin : g_lvl
        logic [(1<<l)-1:0] v;
        if (l == SEL_W) begin : g_leaf
            for (genvar i = 0; i < (1 << l); i++) begin : g_i
                if (i < NUM_INPUTS) begin : g_used
                    assign v[i] = in[i];
                end else begin : g_tie
                    assign v[i] = 1'b0;
                end
            end
        end else begin : g_node
            for (genvar i = 0; i < (1 << l); i++) begin : g_i
                assign v[i] = sel[SEL_W-1-l] ? g_lvl[l+1].v[2*i+1] : g_lvl[l+1].v[2*i];
            end
        end
    end

    assign out = g_lvl[0].v[0];

endmodule

// File: rtl/mux_tree_cfgchain_n.sv
// mux_tree_cfgchain_n: N-input mux with serial shadow config chain, atomic commit and comb/reg output mode
module mux_tree_cfgchain_n
    import mux_tree_cfgchain_n_pkg::*;
#(
    parameter int NUM_INPUTS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_en,
    input  logic                  ccff_head,
    output logic                  ccff_tail,
    input  logic                  cfg_commit,
    output logic                  cfg_done,
    input  logic [NUM_INPUTS-1:0] in,
    output logic                  out
);

    localparam int SEL_W    = clog2(NUM_INPUTS);
    localparam int MODE_BIT = mode_pos(NUM_INPUTS);
    localparam int CFG_W    = SEL_W + 1;
    localparam int CNT_W    = clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_W);

    logic [CFG_W-1:0] shadow;
    logic [CFG_W-1:0] active;
    logic [CNT_W-1:0] shift_cnt;
    logic             out_q;
    logic             mux_c;

    mux_tree_comb_n #(.NUM_INPUTS(NUM_INPUTS)) u_tree (
        .sel (active[SEL_W-1:0]),
        .in  (in),
        .out (mux_c)
    );

    // chain shift, commit (wins over shift) and output register; reset overrides all
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow    <= '0;
            active    <= {CFG_MODE_COMB, {SEL_W{1'b0}}};
            shift_cnt <= '0;
            out_q     <= 1'b0;
        end else begin
            out_q <= mux_c;
            if (cfg_commit) begin
                active    <= shadow;
                shift_cnt <= '0;
            end else if (cfg_en) begin
                shadow    <= {shadow[CFG_W-2:0], ccff_head};
                shift_cnt <= (shift_cnt == CNT_MAX) ? shift_cnt : shift_cnt + 1'b1;
            end
        end
    end

    assign ccff_tail = shadow[CFG_W-1];
    assign cfg_done  = shift_cnt == CNT_MAX;
    assign out       = (active[MODE_BIT] == CFG_MODE_REG) ? out_q : mux_c;

endmodule

// File: tb/tb_mux_tree_cfgchain_n.sv
// tb_mux_tree_cfgchain_n: scoreboard bench for two chained 8-input cells and a 5-input cell
module tb_mux_tree_cfgchain_n;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_en = 1'b0;
    logic       head = 1'b0;
    logic       cfg_commit = 1'b0;
    logic [7:0] in8 = 8'h01;
    logic       t0, t1, d0, d1, o0, o1;
    logic       cfg_en5 = 1'b0;
    logic       head5 = 1'b0;
    logic       commit5 = 1'b0;
    logic [4:0] in5 = 5'b0;
    logic       t5, d5, o5;

    always #5 clk = ~clk;

    mux_tree_cfgchain_n #(.NUM_INPUTS(8)) u0 (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .ccff_head(head), .ccff_tail(t0),
        .cfg_commit(cfg_commit), .cfg_done(d0), .in(in8), .out(o0)
    );

    mux_tree_cfgchain_n #(.NUM_INPUTS(8)) u1 (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .ccff_head(t0), .ccff_tail(t1),
        .cfg_commit(cfg_commit), .cfg_done(d1), .in(in8), .out(o1)
    );

    mux_tree_cfgchain_n #(.NUM_INPUTS(5)) u5 (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en5), .ccff_head(head5), .ccff_tail(t5),
        .cfg_commit(commit5), .cfg_done(d5), .in(in5), .out(o5)
    );

    typedef struct {
        int    sig;
        logic  exp;
        string name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic probe(input int s);
        case (s)
            0: return o0;
            1: return t0;
            2: return d0;
            3: return o1;
            4: return t1;
            5: return d1;
            6: return o5;
            7: return d5;
            default: return t5;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (probe(e.sig) !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %b expected %b", e.name, probe(e.sig), e.exp);
            end
        end
    end

    task automatic chk(input int s, input logic v, input string n);
        q.push_back('{s, v, n});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift(input logic b);
        cfg_en = 1'b1;
        head = b;
        tick();
        cfg_en = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic load5(input logic [3:0] cfg);
        for (int i = 3; i >= 0; i--) begin
            cfg_en5 = 1'b1;
            head5 = cfg[i];
            tick();
        end
        cfg_en5 = 1'b0;
        commit5 = 1'b1;
        tick();
        commit5 = 1'b0;
    endtask

    logic [7:0] pat;
    logic [7:0] tl;

    initial begin
        tick();
        tick();
        chk(0, 1'b1, "rst_out_in0");
        chk(1, 1'b0, "rst_tail");
        chk(2, 1'b0, "rst_done");
        chk(6, 1'b0, "rst_out5");
        chk(7, 1'b0, "rst_done5");
        rst_n = 1'b1;
        tick();
        in8 = 8'h00;
        chk(0, 1'b0, "rst_out_follow0");
        tick();
        in8 = 8'h01;
        chk(0, 1'b1, "rst_out_follow1");

        shift(1'b0);
        shift(1'b1);
        shift(1'b0);
        chk(2, 1'b0, "done_after3");
        shift(1'b1);
        chk(2, 1'b1, "done_after4");
        chk(5, 1'b1, "done1_after4");
        commit();
        in8 = 8'h20;
        chk(0, 1'b1, "comb_sel5_hi");
        chk(2, 1'b0, "done_cleared");
        tick();
        in8 = 8'h00;
        chk(0, 1'b0, "comb_sel5_lo");
        tick();
        in8 = 8'hDF;
        chk(0, 1'b0, "comb_sel5_others");
        tick();
        in8 = 8'h20;
        chk(0, 1'b1, "comb_sel5_again");

        shift(1'b1);
        chk(1, 1'b1, "reg_load_tail1");
        chk(0, 1'b1, "reg_load_out_hold1");
        shift(1'b0);
        chk(1, 1'b0, "reg_load_tail2");
        chk(0, 1'b1, "reg_load_out_hold2");
        shift(1'b1);
        chk(1, 1'b1, "reg_load_tail3");
        shift(1'b1);
        chk(1, 1'b1, "reg_load_tail4");
        commit();
        in8 = 8'h00;
        tick();
        chk(0, 1'b0, "reg_out_low");
        in8 = 8'h08;
        chk(0, 1'b0, "reg_out_latency");
        tick();
        chk(0, 1'b1, "reg_out_rise");
        for (int i = 0; i < 4; i++) begin
            shift(1'b0);
            chk(0, 1'b1, "reg_out_during_shift");
        end
        chk(2, 1'b1, "reg_shift_done");

        pat = 8'b1001_1100;
        tl  = 8'b0001_0011;
        for (int i = 7; i >= 0; i--) begin
            shift(pat[i]);
            chk(1, tl[i], "chain_tail0");
        end
        chk(4, 1'b1, "chain_tail1");
        chk(5, 1'b1, "chain_done1");
        commit();
        in8 = 8'h10;
        tick();
        chk(0, 1'b1, "chain_cell0_sel4");
        chk(3, 1'b0, "chain_cell1_sel1_lo");
        in8 = 8'h02;
        tick();
        chk(0, 1'b0, "chain_cell0_sel4_lo");
        chk(3, 1'b1, "chain_cell1_sel1_hi");

        shift(1'b1);
        shift(1'b0);
        shift(1'b1);
        chk(1, 1'b0, "pre_both_tail");
        cfg_en = 1'b1;
        head = 1'b0;
        cfg_commit = 1'b1;
        in8 = 8'h20;
        tick();
        cfg_en = 1'b0;
        cfg_commit = 1'b0;
        chk(1, 1'b0, "both_tail_hold");
        chk(2, 1'b0, "both_done_clr");
        chk(0, 1'b1, "both_active_sel5");
        pat = 8'b0000_1010;
        for (int i = 3; i >= 0; i--) begin
            shift(1'b0);
            chk(1, pat[i], "both_shadow_held");
            chk(2, i == 0, "both_done_count");
        end

        shift(1'b1);
        cfg_en = 1'b1;
        head = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cfg_en = 1'b0;
        in8 = 8'hFE;
        chk(0, 1'b0, "midrst_out_in0");
        chk(1, 1'b0, "midrst_tail");
        chk(2, 1'b0, "midrst_done");
        tick();
        in8 = 8'h01;
        chk(0, 1'b1, "midrst_out_in0_hi");
        for (int i = 0; i < 4; i++) begin
            shift(1'b1);
            chk(1, i == 3, "midrst_tail_refill");
            chk(2, i == 3, "midrst_done_refill");
        end

        load5(4'b0110);
        in5 = 5'b11111;
        chk(6, 1'b0, "n5_sel6_zero");
        chk(7, 1'b0, "n5_done_clr");
        tick();
        load5(4'b0111);
        chk(6, 1'b0, "n5_sel7_zero");
        tick();
        load5(4'b0100);
        chk(6, 1'b1, "n5_sel4_hi");
        tick();
        in5 = 5'b01111;
        chk(6, 1'b0, "n5_sel4_lo");

        tick();
        tick();
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_tree_cfgchain_n.md
Name: mux_tree_cfgchain_n

Overview:
- Parametrised N-input routing/LUT-style multiplexer with its own configuration-chain memory.
- Replaces fixed 2-input basis muxes driven by external mem/mem_inv with an N-input tree whose select bits are loaded serially.
- Select bits shift through a chain link (ccff_head to ccff_tail) and are applied atomically on commit.
- A configurable output mode selects combinational or registered output.
- Sits in routing blocks and CLB input crossbars, daisy-chained with other configurable cells.

Parameters:
- NUM_INPUTS, 8, number of data inputs; legal range 2..64, need not be a power of 2.
- SEL_W, $clog2(NUM_INPUTS), derived localparam; number of select bits.
- CFG_W, SEL_W+1, derived localparam; number of configuration bits: select bits plus one mode bit.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- cfg_en  input  1  shift enable for the configuration chain.
- ccff_head  input  1  serial configuration data in.
- ccff_tail  output  1  serial configuration data out; feeds the next cell's ccff_head.
- cfg_commit  input  1  one-cycle pulse; copies the shadow chain into the active configuration.
- cfg_done  output  1  high when exactly CFG_W or more shifts have occurred since the last commit or reset.
- in  input  NUM_INPUTS  data inputs; bit i is selected by sel value i.
- out  output  1  multiplexer output.

Behaviour:
- Reset (rst_n=0 at a clk edge): the following registers all clear to 0: shadow[CFG_W-1:0], active[CFG_W-1:0], shift_cnt, out_q. Resulting outputs:
  - ccff_tail=0
  - cfg_done=0
  - out=in[0], combinational, since mode=0 and sel=0
- Reset is applied mid-shift or mid-commit with priority over everything; partial configuration is lost.
- Shift: on cfg_en=1 with cfg_commit=0:
  - shadow <= {shadow[CFG_W-2:0], ccff_head}
  - ccff_tail = shadow[CFG_W-1] (registered, so one cycle of chain latency per cell)
  - The first bit shifted in ends up as the MSB (mode bit) after CFG_W shifts.
- shift_cnt increments on each shift and saturates at CFG_W; cfg_done = (shift_cnt==CFG_W).
- Shifting never disturbs active or out; configuration is glitch-free while loading.
- Commit: on cfg_commit=1:
  - active <= shadow and shift_cnt <= 0.
  - If cfg_en=1 in the same cycle, commit wins: the shift is suppressed and shadow holds.
  - Commit with cfg_done=0 is legal and copies whatever shadow holds; no error flag.
- Decode:
  - sel = active[SEL_W-1:0]
  - mode = active[SEL_W]
  - mux_c = in[sel] if sel < NUM_INPUTS, else 1'b0 (out-of-range select for non-power-of-2 N).
- Output:
  - out_q <= mux_c every cycle, independent of mode.
  - out = mode ? out_q : mux_c.
  - Mode 0 has zero latency from in to out.
  - Mode 1 has one-cycle latency; the first registered value after commit reflects the new sel.
- The new configuration takes effect on the cycle after the commit edge: the active register is updated at that edge.
- No X propagation: every state register has a reset value; no latches.

Decomposition:
- Shared include/package holds:
  - CFG_MODE_COMB=1'b0, CFG_MODE_REG=1'b1
  - the mode bit position macro (SEL_W)
  - a clog2 helper function for tools lacking $clog2
- One natural sub-module, mux_tree_comb_n:
  - purely combinational, NUM_INPUTS-input tree of 2:1 basis stages
  - sel[0] drives the leaf level
  - unused leaves are tied to 0, giving the out-of-range-select-returns-0 behaviour
- The parent owns the chain, counter, commit and output register.

Test Plan:
- Reset: NUM_INPUTS=8, rst_n low 2 cycles, in=8'b0000_0001 -> out=1, ccff_tail=0, cfg_done=0; flip in[0] -> out follows in the same cycle.
- Load and commit, combinational: shift 4 bits 0,1,0,1 (mode=0, sel=5), then commit; in=8'b0010_0000 -> cfg_done=1 after the 4th shift, 0 after commit; out=1 the cycle after commit; toggling in[5] toggles out combinationally.
- Registered mode: shift 1,0,1,1 (mode=1, sel=3), commit; drive in[3] 0->1 at cycle t -> out rises at t+1; out stays unchanged during a subsequent 4-bit shift without commit.
- Chain pass-through: two instances chained, 8 shifts of pattern 1,0,0,1,1,1,0,0 -> first cell shadow=4'b1100, second=4'b1001; ccff_tail of the first equals its shadow MSB each cycle.
- Simultaneous cfg_en and cfg_commit: shadow holds, active loads the old shadow, shift_cnt=0; reset asserted during a 2-bit partial shift -> all state 0, out=in[0].
- Non-power-of-2: NUM_INPUTS=5, commit sel=6 (mode 0), in=5'b11111 -> out=0; commit sel=4 -> out=1.
